// File: rtl/mem_stage_if.sv
// -----------------------------------------------------------------------------
// mem_stage_if -- data-memory request/response bus between mem_stage and the
// data memory (or cache).
//
// Signals:
//   req_valid  request valid (master -> slave)
//   req_wr     1 = write, 0 = read
//   req_ready  slave accepts the request this cycle
//   req_addr   word-aligned request address (low 2 bits always 0)
//   req_wstrb  byte write strobes
//   req_wdata  lane-shifted write data
//   resp_valid load response valid, one per accepted read
//   resp_rdata load response data (full word)
//
// Modports: master = pipeline stage side, slave = memory side.
// -----------------------------------------------------------------------------
interface mem_stage_if;
    logic        req_valid;
    logic        req_wr;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [3:0]  req_wstrb;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;

    modport master (
        output req_valid, req_wr, req_addr, req_wstrb, req_wdata,
        input  req_ready, resp_valid, resp_rdata
    );

    modport slave (
        input  req_valid, req_wr, req_addr, req_wstrb, req_wdata,
        output req_ready, resp_valid, resp_rdata
    );
endinterface

// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage -- memory-access pipeline stage. Accepts one op at a time from
// execute, issues load/store requests on the data-memory bus, aligns and
// extends load data, and presents the result in a writeback output register
// that also feeds the decode-stage bypass.
//
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   flush            exception/ertn flush; kills the in-flight op
//   in_*             upstream op (valid/ready, op, unsigned, addr, wdata, rd, we)
//   mem              data-memory bus (mem_stage_if.master)
//   out_*            writeback handshake and fields (out_ale = misaligned addr)
//   byp_*            forwarding of the output register to decode
//   load_pending     a load is in flight and its result is not yet registered
//
// Build option: define MEM_ALIGN_CHECK_EN to raise out_ale on misaligned
// half/word accesses instead of issuing a request. When undefined, the
// offending low address bits are ignored and out_ale stays 0.
// -----------------------------------------------------------------------------
module mem_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_op,
    input  logic        in_unsigned,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_wdata,
    input  logic [4:0]  in_rd,
    input  logic        in_we,
    mem_stage_if.master mem,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [4:0]  out_rd,
    output logic        out_we,
    output logic [31:0] out_data,
    output logic        out_ale,
    output logic        byp_valid,
    output logic [4:0]  byp_rd,
    output logic [31:0] byp_data,
    output logic        load_pending
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} state_e;

    state_e      state_q, state_d;
    logic        is_load_q, is_load_d;
    logic [1:0]  size_q, size_d;
    logic        unsigned_q, unsigned_d;
    logic [31:0] addr_q, addr_d;
    logic [4:0]  rd_q, rd_d;
    logic        we_q, we_d;
    logic        req_valid_q, req_valid_d;
    logic [3:0]  req_wstrb_q, req_wstrb_d;
    logic [31:0] req_wdata_q, req_wdata_d;
    logic        out_valid_q, out_valid_d;
    logic [4:0]  out_rd_q, out_rd_d;
    logic        out_we_q, out_we_d;
    logic [31:0] out_data_q, out_data_d;
    logic        out_ale_q, out_ale_d;
    logic        load_pending_q, load_pending_d;

    logic        accept;
    logic        mem_op;
    logic        misaligned;
    logic [3:0]  wstrb;
    logic [31:0] wdata_lane;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_data;

    assign in_ready = (state_q == IDLE) && (!out_valid_q || out_ready) && !flush;
    assign accept   = in_valid && in_ready;
    assign mem_op   = in_op[0] || in_op[1];

`ifdef MEM_ALIGN_CHECK_EN
    assign misaligned = mem_op &&
                        (((in_op[3:2] == 2'b01) && in_addr[0]) ||
                         (in_op[3] && (in_addr[1:0] != 2'b00)));
`else
    assign misaligned = 1'b0;
`endif

    // Store lane steering. Half strobes use only addr[1] so a stray addr[0]
    // cannot produce a strobe that straddles the word boundary.
    always_comb begin
        case (in_op[3:2])
            2'b00: begin
                wstrb      = 4'b0001 << in_addr[1:0];
                wdata_lane = {4{in_wdata[7:0]}};
            end
            2'b01: begin
                wstrb      = 4'b0011 << {in_addr[1], 1'b0};
                wdata_lane = {2{in_wdata[15:0]}};
            end
            default: begin
                wstrb      = 4'b1111;
                wdata_lane = in_wdata;
            end
        endcase
    end

    // Load alignment and extension from the registered address/size.
    always_comb begin
        case (addr_q[1:0])
            2'b00:   byte_sel = mem.resp_rdata[7:0];
            2'b01:   byte_sel = mem.resp_rdata[15:8];
            2'b10:   byte_sel = mem.resp_rdata[23:16];
            default: byte_sel = mem.resp_rdata[31:24];
        endcase
        half_sel = addr_q[1] ? mem.resp_rdata[31:16] : mem.resp_rdata[15:0];
        case (size_q)
            2'b00:   load_data = {{24{!unsigned_q && byte_sel[7]}}, byte_sel};
            2'b01:   load_data = {{16{!unsigned_q && half_sel[15]}}, half_sel};
            default: load_data = mem.resp_rdata;
        endcase
    end

    always_comb begin
        // NOTE: every _d starts from its _q so no path leaves a variable unassigned (no latch).
        state_d     = state_q;
        is_load_d   = is_load_q;
        size_d      = size_q;
        unsigned_d  = unsigned_q;
        addr_d      = addr_q;
        rd_d        = rd_q;
        we_d        = we_q;
        req_wstrb_d = req_wstrb_q;
        req_wdata_d = req_wdata_q;
        out_rd_d    = out_rd_q;
        out_we_d    = out_we_q;
        out_data_d  = out_data_q;
        out_ale_d   = out_ale_q;
        // A consumed result drops out_valid unless a new one lands below.
        out_valid_d = out_valid_q && !out_ready;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (!mem_op || misaligned) begin
                        out_valid_d = 1'b1;
                        out_rd_d    = in_rd;
                        out_we_d    = in_we && !misaligned;
                        out_data_d  = in_addr;
                        out_ale_d   = misaligned;
                    end else begin
                        state_d     = REQ;
                        is_load_d   = in_op[0];
                        size_d      = in_op[3:2];
                        unsigned_d  = in_unsigned;
                        addr_d      = in_addr;
                        rd_d        = in_rd;
                        we_d        = in_we;
                        req_wstrb_d = in_op[0] ? 4'b0000 : wstrb;
                        req_wdata_d = wdata_lane;
                    end
                end
            end
            REQ: begin
                if (mem.req_ready) begin
                    if (flush) begin
                        // An accepted load still owes a response that must be swallowed.
                        state_d = is_load_q ? DRAIN : IDLE;
                    end else if (is_load_q) begin
                        state_d = WAIT;
                    end else begin
                        state_d     = IDLE;
                        out_valid_d = 1'b1;
                        out_rd_d    = rd_q;
                        out_we_d    = 1'b0;
                        out_data_d  = addr_q;
                        out_ale_d   = 1'b0;
                    end
                end else if (flush) begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (flush) begin
                    state_d = mem.resp_valid ? IDLE : DRAIN;
                end else if (mem.resp_valid) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b1;
                    out_rd_d    = rd_q;
                    out_we_d    = we_q;
                    out_data_d  = load_data;
                    out_ale_d   = 1'b0;
                end
            end
            default: begin
                if (mem.resp_valid) begin
                    state_d = IDLE;
                end
            end
        endcase

        if (flush) begin
            out_valid_d = 1'b0;
        end
        req_valid_d    = (state_d == REQ);
        load_pending_d = ((state_d == REQ) || (state_d == WAIT)) && is_load_d;
    end

    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            is_load_q      <= 1'b0;
            size_q         <= 2'b00;
            unsigned_q     <= 1'b0;
            addr_q         <= '0;
            rd_q           <= '0;
            we_q           <= 1'b0;
            req_valid_q    <= 1'b0;
            req_wstrb_q    <= '0;
            req_wdata_q    <= '0;
            out_valid_q    <= 1'b0;
            out_rd_q       <= '0;
            out_we_q       <= 1'b0;
            out_data_q     <= '0;
            out_ale_q      <= 1'b0;
            load_pending_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            is_load_q      <= is_load_d;
            size_q         <= size_d;
            unsigned_q     <= unsigned_d;
            addr_q         <= addr_d;
            rd_q           <= rd_d;
            we_q           <= we_d;
            req_valid_q    <= req_valid_d;
            req_wstrb_q    <= req_wstrb_d;
            req_wdata_q    <= req_wdata_d;
            out_valid_q    <= out_valid_d;
            out_rd_q       <= out_rd_d;
            out_we_q       <= out_we_d;
            out_data_q     <= out_data_d;
            out_ale_q      <= out_ale_d;
            load_pending_q <= load_pending_d;
        end
    end

    assign mem.req_valid = req_valid_q;
    assign mem.req_wr    = !is_load_q;
    assign mem.req_addr  = {addr_q[31:2], 2'b00};
    assign mem.req_wstrb = req_wstrb_q;
    assign mem.req_wdata = req_wdata_q;

    assign out_valid    = out_valid_q;
    assign out_rd       = out_rd_q;
    assign out_we       = out_we_q;
    assign out_data     = out_data_q;
    assign out_ale      = out_ale_q;
    assign load_pending = load_pending_q;

    assign byp_valid = out_valid_q && out_we_q && !out_ale_q;
    assign byp_rd    = out_rd_q;
    assign byp_data  = out_data_q;
endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
Parameters: none; all widths fixed.
REQ-001 clk  input  1  clock; all state updates on rising edge.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 flush  input  1  exception/ertn flush; kills in-flight op.
REQ-004 in_valid  input  1  upstream (execute) op valid.
REQ-005 in_ready  output  1  stage accepts op this cycle.
REQ-006 in_op  input  4  [0]=load, [1]=store, [3:2]=size (00 byte, 01 half, 10 word); both 0 = non-memory op.
REQ-007 in_unsigned  input  1  zero-extend load data when 1.
REQ-008 in_addr  input  32  effective address / ALU result.
REQ-009 in_wdata  input  32  store data (rs2), unshifted.
REQ-010 in_rd  input  5  destination register index.
REQ-011 in_we  input  1  destination write enable.
REQ-012 req_valid, req_wr  output  1 each  data-memory request valid; 1=write.
REQ-013 req_ready  input  1  memory accepts request.
REQ-014 req_addr  output  32  request address, word-aligned (low 2 bits 0).
REQ-015 req_wstrb  output  4  byte strobes; req_wdata output 32 lane-shifted data.
REQ-016 resp_valid  input  1; resp_rdata input 32  load response, one per accepted load.
REQ-017 out_valid  output  1; out_ready input 1  writeback handshake.
REQ-018 out_rd 5, out_we 1, out_data 32, out_ale 1  outputs  writeback fields; out_ale = misaligned-address exception.
REQ-019 byp_valid 1, byp_rd 5, byp_data 32  outputs  forwarding to decode.
REQ-020 load_pending  output  1  load accepted but result not yet in output register (decode stalls dependent ops).

Function
REQ-021 FSM states IDLE, REQ, WAIT, DRAIN.
REQ-022 in_ready = (state==IDLE) & (!out_valid | out_ready) & !flush.
REQ-023 Non-memory op accepted at T: out_valid=1 at T+1, out_data=in_addr, FSM stays IDLE.
REQ-024 Memory op accepted at T: IDLE->REQ; req_valid=1 from T+1, fields stable until req_ready.
REQ-025 Store: req_ready in REQ -> IDLE; out_valid=1 next cycle, out_we=0.
REQ-026 Load: req_ready in REQ -> WAIT; resp_valid in WAIT -> IDLE; out_valid=1 next cycle, out_we=in_we.
REQ-027 Store strobes: byte 4'b0001<<a[1:0], half 4'b0011<<a[1:0], word 4'b1111; req_wdata = data replicated per byte/half lane.
REQ-028 Load data: select byte/half by addr[1:0], sign-extend unless in_unsigned; word passes through.
REQ-029 out_valid clears on out_ready when no new result is written the same cycle; a same-cycle new result keeps out_valid=1.
REQ-030 byp_valid = out_valid & out_we & !out_ale; byp_rd/byp_data = out_rd/out_data.
REQ-031 load_pending = 1 in REQ or WAIT for a load.
REQ-032 Flush in IDLE or REQ: out_valid->0, state->IDLE; in REQ, a request accepted that same cycle becomes DRAIN when it is a load.
REQ-033 Flush in WAIT: out_valid->0, state->DRAIN unless resp_valid the same cycle (then IDLE).
REQ-034 DRAIN: req_valid=0, in_ready=0; resp_valid discarded -> IDLE.
REQ-035 rd=0 with in_we=1 still writes back; writeback stage ignores x0.

Reset
REQ-036 On reset: state=IDLE; out_valid, req_valid, out_we, out_ale, byp_valid, load_pending = 0; out_data, out_rd = 0.
REQ-037 Reset mid-transaction abandons it without draining; memory side is reset together.

Configuration
REQ-038 Macro MEM_ALIGN_CHECK_EN.
- Defined: half with addr[0]=1 or word with addr[1:0]!=0 issues no request; out_valid at T+1, out_ale=1, out_we=0, out_data=in_addr (BADV).
- Undefined: no check; offending low bits ignored; out_ale tied 0.

Verification
REQ-039 Load word addr 0x100, resp 0xDEADBEEF after 3 cycles -> req_addr=0x100, out_data=0xDEADBEEF, out_we=1, load_pending high through REQ/WAIT.
REQ-040 Load byte signed addr 0x103, rdata 0x80FFFFFF -> out_data=0xFFFFFF80; unsigned -> 0x00000080.
REQ-041 Store half addr 0x202 data 0x1234 -> req_wstrb=4'b1100, req_wdata=0x12341234, out_we=0.
REQ-042 Flush in WAIT, resp arrives 2 cycles later -> DRAIN, no out_valid, in_ready 0 until response consumed.
REQ-043 out_ready low 4 cycles after non-memory op -> out_valid/out_data held, in_ready=0.
REQ-044 With MEM_ALIGN_CHECK_EN: load word addr 0x101 -> no req_valid, out_ale=1, out_data=0x101; without it: req_addr=0x100.
